vga_fb_arbiter: RTL
===================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port frame-buffer RAM between the VGA pixel fetch and a pixel writer.
//  - The VGA timing block issues pixel reads that must return at a fixed latency.
//  - The drawing/button logic writes pixels through a valid/ready port.
//  - Video reads always win; writes fill the free slots.
//  - Sits between the VGA timing generator, the pixel-writer FSM and the RAM.
// PARAMETERS
//  AW       15     address width (word address, 1 pixel per word)
//  DW       3      pixel width, {R,G,B}
//  FB_SIZE  19200  valid pixel count (160x120); addresses >= FB_SIZE are out of range
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  vid_req    in   1   1-cycle pulse: fetch pixel at vid_addr
//  vid_addr   in   AW  read address, sampled with vid_req
//  vid_data   out  DW  pixel returned to the VGA output stage
//  vid_rvalid out  1   1-cycle pulse, vid_data valid
//  vid_ovr    out  1   sticky: vid_req arrived while a read was still in flight
//  wr_valid   in   1   writer has a pixel
//  wr_ready   out  1   arbiter accepts the pixel this cycle
//  wr_addr    in   AW  write address
//  wr_data    in   DW  write pixel
//  clr_start  in   1   pulse: start a full-buffer fill (FB_CLEAR_EN only)
//  clr_color  in   DW  fill colour, sampled at clr_start
//  clr_busy   out  1   fill in progress
//  mem_en     out  1   RAM enable (registered)
//  mem_we     out  1   RAM write enable (registered)
//  mem_addr   out  AW  RAM address (registered)
//  mem_wdata  out  DW  RAM write data (registered)
//  mem_rdata  in   DW  RAM read data, valid 1 cycle after mem_en && !mem_we
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, vid_ovr = 0, clr_busy = 0.
//    - Reset mid-operation discards any in-flight read (no vid_rvalid) and aborts the fill.
//  Arbitration: decided in cycle N, RAM command on registered mem_* in cycle N+1.
//    - Priority: vid_req > fill > writer.
//    - Exactly one RAM command per cycle; mem_en = 0 when idle.
//  FSM states (state = command issued this cycle):
//    - IDLE: no command.
//    - VRD: video read.
//    - WR: writer write.
//    - CLR: fill write.
//    - Next state is re-chosen every cycle by priority; there is no multi-cycle hold.
//  Video read, fixed latency 3:
//    - vid_req @N -> mem read @N+1 -> mem_rdata @N+2 -> vid_data/vid_rvalid @N+3.
//    - vid_data holds its value until the next vid_rvalid.
//  Out-of-range read (vid_addr >= FB_SIZE):
//    - No RAM access (mem_en stays 0); the slot goes to the next requester.
//    - vid_data = 0, vid_rvalid @N+3 still; latency is unchanged.
//  vid_req spacing: at least 2 cycles apart.
//    - A vid_req at N+1 following one at N is dropped.
//    - The drop sets vid_ovr (sticky until rst); the first read completes normally.
//  Writer: wr_ready = !vid_req && !clr_busy (combinational).
//    - Transfer when wr_valid && wr_ready @N -> mem write @N+1.
//    - wr_addr >= FB_SIZE: transfer is accepted (wr_ready honoured) but no RAM write is issued.
//  Writer progress: since vid_req is at most every 2nd cycle, the writer gets >= 1 slot per 2 cycles.
//  Simultaneous vid_req && wr_valid: video wins; wr_ready = 0; the writer must hold its data.
// CONFIGURATION
//  FB_CLEAR_EN defined (fill engine compiled in):
//    - clr_start while !clr_busy: latch clr_color, counter = 0, clr_busy = 1.
//    - Each cycle without vid_req: write clr_color at counter, counter++.
//    - The write at FB_SIZE-1 clears clr_busy in the following cycle.
//    - clr_start while busy is ignored.
//    - wr_ready = 0 throughout the fill.
//    - Counter wrap is impossible: it stops at FB_SIZE-1.
//  FB_CLEAR_EN undefined:
//    - No counter.
//    - clr_start and clr_color are ignored.
//    - clr_busy is tied 0.
//    - wr_ready = !vid_req.
// TESTING
//  1 rst=1 for 200 time units, then release -> all mem_*, vid_*, wr_ready=1, clr_busy=0; no RAM cycle.
//  2 Preload RAM[100]=3'b101; vid_req, vid_addr=100 @N -> mem_en=1, we=0, addr=100 @N+1; vid_data=101, vid_rvalid @N+3.
//  3 wr_valid, wr_addr=5, wr_data=3'b010 held; vid_req in same cycle -> wr_ready=0; next cycle wr_ready=1, mem write (5,010) one cycle later; readback=010.
//  4 vid_req on 2 consecutive cycles -> one RAM read, one vid_rvalid, vid_ovr=1 and stays 1 until rst.
//  5 vid_req, vid_addr=19200 -> mem_en stays 0 for that slot; vid_data=0, vid_rvalid @N+3.
//  6 (FB_CLEAR_EN) clr_start, clr_color=3'b111 with vid_req every 4 cycles
//     -> all 19200 words = 111; clr_busy falls after the last write; video latency stays 3 throughout.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the video-read, pixel-writer, fill-control and RAM-command signals around the
// frame-buffer arbiter. The slave side is the arbiter; the master side is everything around it.
interface vga_fb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_rvalid;
  logic          vid_ovr;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output vid_req, vid_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    input  vid_data, vid_rvalid, vid_ovr, wr_ready, clr_busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  vid_req, vid_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    output vid_data, vid_rvalid, vid_ovr, wr_ready, clr_busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: fixed-latency video reads win, fill engine next, writer last.
// Define FB_CLEAR_EN to compile in the full-buffer fill engine (clr_start/clr_color/clr_busy).
module vga_fb_arbiter #(
  parameter int AW      = 15,
  parameter int DW      = 3,
  parameter int FB_SIZE = 19200
) (
  input  logic              clk,
  input  logic              rst,
  vga_fb_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, VRD, WR, CLR} state_t;

  state_t        state, next_state;
  logic          rd_p1, rd_p1_oor, rd_p2, rd_p2_oor;
  logic          vid_take, vid_oor, vid_go;
  logic          wr_oor, wr_fire;
  logic          busy;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_col;

  // A request right behind an accepted one is dropped; out-of-range reads keep their slot in the
  // read pipeline (for the fixed latency) but never touch the RAM.
  assign vid_oor  = bus.vid_addr >= AW'(FB_SIZE);
  assign vid_take = bus.vid_req && !rd_p1;
  assign vid_go   = vid_take && !vid_oor;

  assign wr_oor       = bus.wr_addr >= AW'(FB_SIZE);
  assign bus.wr_ready = !bus.vid_req && !busy;
  assign wr_fire      = bus.wr_valid && bus.wr_ready && !wr_oor;

  // NOTE: every output of this combinational block gets a default first, so no latch is inferred.
  always_comb begin
    next_state = IDLE;
    if (vid_go)       next_state = VRD;
    else if (busy)    next_state = CLR;
    else if (wr_fire) next_state = WR;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state <= next_state;
      case (next_state)
        VRD: bus.mem_addr <= bus.vid_addr;
        WR: begin
          bus.mem_addr  <= bus.wr_addr;
          bus.mem_wdata <= bus.wr_data;
        end
        CLR: begin
          bus.mem_addr  <= clr_cnt;
          bus.mem_wdata <= clr_col;
        end
        default: ;
      endcase
    end
  end

  // State is the command on the RAM this cycle, so the strobes decode straight from the flops.
  assign bus.mem_en = (state != IDLE);
  assign bus.mem_we = (state == WR) || (state == CLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p1          <= 1'b0;
      rd_p1_oor      <= 1'b0;
      rd_p2          <= 1'b0;
      rd_p2_oor      <= 1'b0;
      bus.vid_rvalid <= 1'b0;
      bus.vid_data   <= '0;
      bus.vid_ovr    <= 1'b0;
    end else begin
      rd_p1          <= vid_take;
      rd_p1_oor      <= vid_oor;
      rd_p2          <= rd_p1;
      rd_p2_oor      <= rd_p1_oor;
      bus.vid_rvalid <= rd_p2;
      if (rd_p2) bus.vid_data <= rd_p2_oor ? DW'(0) : bus.mem_rdata;
      if (bus.vid_req && rd_p1) bus.vid_ovr <= 1'b1;
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      clr_cnt <= '0;
      clr_col <= '0;
    end else if (bus.clr_start && !busy) begin
      busy    <= 1'b1;
      clr_cnt <= '0;
      clr_col <= bus.clr_color;
    end else if (next_state == CLR) begin
      // The counter parks on the last word; the write there ends the fill.
      if (clr_cnt == AW'(FB_SIZE - 1)) busy <= 1'b0;
      else                             clr_cnt <= clr_cnt + AW'(1);
    end
  end
`else
  logic unused_clr;
  assign busy       = 1'b0;
  assign clr_cnt    = '0;
  assign clr_col    = '0;
  assign unused_clr = ^{bus.clr_start, bus.clr_color};
`endif

  assign bus.clr_busy = busy;

endmodule
